// File: rtl/gpi_pkg.sv
// gpi_pkg: register offsets and limits shared by the GPI slot
package gpi_pkg;
  localparam logic [4:0] GPI_REG_DATA    = 5'd0;
  localparam logic [4:0] GPI_REG_RISE    = 5'd1;
  localparam logic [4:0] GPI_REG_FALL    = 5'd2;
  localparam logic [4:0] GPI_REG_RISE_EN = 5'd3;
  localparam logic [4:0] GPI_REG_FALL_EN = 5'd4;
  localparam int         GPI_MAX_W       = 32;
endpackage

// File: rtl/gpi_debounce.sv
// gpi_debounce: 2-FF synchronizer plus tick-sampled debounce; a level is accepted
// once it is seen at two consecutive ticks
module gpi_debounce #(
  parameter int W        = 8,
  parameter int DB_TICKS = 50000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] gpi_in,
  output logic [W-1:0] db,
  output logic [W-1:0] db_d
);
  localparam int CW = $clog2(DB_TICKS);
  logic [W-1:0] sync1_q, sync2_q, samp_q, samp_d, db_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick;
  always_comb begin
    tick = cnt_q == CW'(DB_TICKS - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    samp_d = tick ? sync2_q : samp_q;
    // bits that agree with the previous sample take the new level, the rest hold
    db_d = tick ? (sync2_q & samp_q) | (db_q & (sync2_q ^ samp_q)) : db_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q <= '0;
      samp_q <= '0;
      db_q <= '0;
    end else begin
      sync1_q <= gpi_in;
      sync2_q <= sync1_q;
      cnt_q <= cnt_d;
      samp_q <= samp_d;
      db_q <= db_d;
    end
  end
  assign db = db_q;
endmodule

// File: rtl/mmio_gpi.sv
// mmio_gpi: debounced input slot with sticky W1C edge flags and a maskable level irq
module mmio_gpi
  import gpi_pkg::*;
#(
  parameter int W        = 8,
  parameter int DB_TICKS = 50000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   reg_addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  input  logic [W-1:0] gpi_in,
  output logic         irq
);
  logic [W-1:0] db, db_d, wdata;
  logic [W-1:0] rise_q, rise_d, fall_q, fall_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic we, irq_q, irq_d, unused_ok;
  gpi_debounce #(.W(W), .DB_TICKS(DB_TICKS)) u_debounce (
    .clk(clk),
    .reset_n(reset_n),
    .gpi_in(gpi_in),
    .db(db),
    .db_d(db_d)
  );
  always_comb begin
    we = cs && write;
    wdata = wr_data[W-1:0];
    // edges come from the debounced next state so flags land with DATA; set beats clear
    rise_d = (rise_q & ~((we && reg_addr == GPI_REG_RISE) ? wdata : '0)) | (db_d & ~db);
    fall_d = (fall_q & ~((we && reg_addr == GPI_REG_FALL) ? wdata : '0)) | (db & ~db_d);
    rise_en_d = (we && reg_addr == GPI_REG_RISE_EN) ? wdata : rise_en_q;
    fall_en_d = (we && reg_addr == GPI_REG_FALL_EN) ? wdata : fall_en_q;
    irq_d = |((rise_q & rise_en_q) | (fall_q & fall_en_q));
    rd_data = (reg_addr == GPI_REG_DATA)    ? 32'(db) :
              (reg_addr == GPI_REG_RISE)    ? 32'(rise_q) :
              (reg_addr == GPI_REG_FALL)    ? 32'(fall_q) :
              (reg_addr == GPI_REG_RISE_EN) ? 32'(rise_en_q) :
              (reg_addr == GPI_REG_FALL_EN) ? 32'(fall_en_q) : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rise_q <= '0;
      fall_q <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      irq_q <= irq_d;
    end
  end
  assign irq = irq_q;
  assign unused_ok = ^{read, wr_data};
endmodule

// File: tb/tb_mmio_gpi.sv
// tb_mmio_gpi: directed, table-driven and randomized model-checked test of mmio_gpi
module tb_mmio_gpi;
  import gpi_pkg::*;
  localparam int W = 8;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic reset_n, cs, read, write, irq;
  logic [4:0] reg_addr;
  logic [31:0] wr_data, rd_data;
  logic [W-1:0] gpi_in;
  int tests = 0;
  int fails = 0;

  mmio_gpi #(.W(W), .DB_TICKS(DB)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data),
    .gpi_in(gpi_in), .irq(irq)
  );

  always #50 clk = ~clk;

  // reference model: pin history queue, tick from cycle count since reset
  logic [W-1:0] hist[$];
  logic [W-1:0] m_samp, m_db, m_rise, m_fall, m_ren, m_fen;
  logic m_irq;
  int m_n;

  task automatic model_step();
    logic [W-1:0] s, nd, rclr, fclr;
    logic we;
    if (!reset_n) begin
      hist = {W'(0), W'(0)};
      m_samp = '0; m_db = '0; m_rise = '0; m_fall = '0; m_ren = '0; m_fen = '0;
      m_irq = 1'b0; m_n = 0;
      return;
    end
    s = hist[0];
    hist.push_back(gpi_in);
    void'(hist.pop_front());
    nd = m_db;
    if (m_n % DB == DB - 1) begin
      for (int i = 0; i < W; i++) if (s[i] == m_samp[i]) nd[i] = s[i];
      m_samp = s;
    end
    m_n++;
    m_irq = |((m_rise & m_ren) | (m_fall & m_fen));
    we = cs && write;
    rclr = (we && reg_addr == 5'd1) ? wr_data[W-1:0] : '0;
    fclr = (we && reg_addr == 5'd2) ? wr_data[W-1:0] : '0;
    m_rise = (m_rise & ~rclr) | (nd & ~m_db);
    m_fall = (m_fall & ~fclr) | (~nd & m_db);
    if (we && reg_addr == 5'd3) m_ren = wr_data[W-1:0];
    if (we && reg_addr == 5'd4) m_fen = wr_data[W-1:0];
    m_db = nd;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    case (a)
      5'd0: return 32'(m_db);
      5'd1: return 32'(m_rise);
      5'd2: return 32'(m_fall);
      5'd3: return 32'(m_ren);
      5'd4: return 32'(m_fen);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
  endtask

  task automatic peek(input logic [4:0] a, output logic [31:0] v);
    cs = 1'b0; write = 1'b0; reg_addr = a;
    #1 v = rd_data;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; reg_addr = a; wr_data = d;
    cyc();
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic wait_bit(input logic [4:0] a, input int b, input logic v, output int n);
    logic [31:0] r;
    n = 0;
    do begin
      cyc();
      n++;
      peek(a, r);
    end while (r[b] !== v && n < 14);
  endtask

  typedef struct {
    logic [4:0]  a;
    logic        we;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[16];

  initial begin
    logic [31:0] r, acc_d, acc_r;
    logic acc_i;
    int n;
    tbl = '{
      '{5'd0,  1'b1, 32'hFFFF_FFFF, 32'h05}, '{5'd0,  1'b0, 32'h0, 32'h05},
      '{5'd7,  1'b1, 32'hFFFF_FFFF, 32'h00}, '{5'd1,  1'b0, 32'h0, 32'h00},
      '{5'd2,  1'b0, 32'h0, 32'h00},         '{5'd3,  1'b0, 32'h0, 32'h00},
      '{5'd4,  1'b0, 32'h0, 32'h00},         '{5'd5,  1'b0, 32'h0, 32'h00},
      '{5'd6,  1'b0, 32'h0, 32'h00},         '{5'd7,  1'b0, 32'h0, 32'h00},
      '{5'd3,  1'b1, 32'hFFFF_FFFF, 32'h00}, '{5'd3,  1'b0, 32'h0, 32'hFF},
      '{5'd4,  1'b1, 32'h1234_5678, 32'h00}, '{5'd4,  1'b0, 32'h0, 32'h78},
      '{5'd31, 1'b1, 32'hFFFF_FFFF, 32'h00}, '{5'd31, 1'b0, 32'h0, 32'h00}
    };
    reset_n = 1'b0; gpi_in = 8'hFF; cs = 1'b0; write = 1'b0; read = 1'b0;
    reg_addr = '0; wr_data = '0;

    // reset with pins high
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_irq", 32'(irq), 0);
    end
    for (int a = 0; a < 8; a++) begin
      peek(5'(a), r);
      chk("rst_rd", r, 0);
    end
    reset_n = 1'b1;
    wait_bit(GPI_REG_DATA, 0, 1'b1, n);
    chk("rst_lat_ok", 32'(n <= 10), 1);
    peek(GPI_REG_DATA, r); chk("rst_data", r, 32'hFF);
    peek(GPI_REG_RISE, r); chk("rst_rise", r, 32'hFF);

    // glitch rejection
    gpi_in = 8'h00;
    wait_bit(GPI_REG_DATA, 0, 1'b0, n);
    chk("fall_all_lat_ok", 32'(n >= 7 && n <= 10), 1);
    wr(GPI_REG_RISE, 32'hFF);
    wr(GPI_REG_FALL, 32'hFF);
    wr(GPI_REG_RISE_EN, 32'h01);
    acc_d = '0; acc_r = '0; acc_i = 1'b0;
    gpi_in = 8'h01;
    for (int i = 0; i < 19; i++) begin
      if (i == 3) gpi_in = 8'h00;
      cyc();
      peek(GPI_REG_DATA, r); acc_d |= r;
      peek(GPI_REG_RISE, r); acc_r |= r;
      acc_i |= irq;
    end
    chk("glitch_data", acc_d, 0);
    chk("glitch_rise", acc_r, 0);
    chk("glitch_irq", 32'(acc_i), 0);

    // stable rising edge and irq
    gpi_in = 8'h01;
    wait_bit(GPI_REG_DATA, 0, 1'b1, n);
    chk("rise_lat_ok", 32'(n >= 7 && n <= 10), 1);
    peek(GPI_REG_DATA, r); chk("rise_data", r, 32'h01);
    peek(GPI_REG_RISE, r); chk("rise_flag", r, 32'h01);
    chk("rise_irq_pre", 32'(irq), 0);
    cyc();
    chk("rise_irq", 32'(irq), 1);
    wr(GPI_REG_RISE, 32'h01);
    peek(GPI_REG_RISE, r); chk("rise_w1c", r, 0);
    cyc();
    chk("rise_irq_clr", 32'(irq), 0);

    // falling edge on bit 7
    gpi_in = 8'h81;
    wait_bit(GPI_REG_DATA, 7, 1'b1, n);
    wr(GPI_REG_RISE, 32'hFF);
    wr(GPI_REG_FALL_EN, 32'h80);
    gpi_in = 8'h01;
    wait_bit(GPI_REG_DATA, 7, 1'b0, n);
    chk("fall_lat_ok", 32'(n >= 7 && n <= 10), 1);
    peek(GPI_REG_FALL, r); chk("fall_flag", r, 32'h80);
    cyc();
    chk("fall_irq", 32'(irq), 1);
    wr(GPI_REG_FALL, 32'h00);
    peek(GPI_REG_FALL, r); chk("fall_w0_keep", r, 32'h80);
    chk("fall_irq_keep", 32'(irq), 1);
    wr(GPI_REG_FALL, 32'hFF);
    cyc();
    chk("fall_irq_clr", 32'(irq), 0);

    // clear and set on the same edge: set wins
    gpi_in = 8'h05;
    n = 0;
    do begin
      peek(GPI_REG_DATA, r);
      if (r[2]) break;
      cs = 1'b1; write = 1'b1; reg_addr = GPI_REG_RISE; wr_data = 32'h04;
      cyc();
      n++;
    end while (n < 14);
    chk("coll_seen", 32'(r[2]), 1);
    peek(GPI_REG_RISE, r); chk("coll_rise", 32'(r[2]), 1);
    cyc();
    peek(GPI_REG_RISE, r); chk("coll_rise_hold", 32'(r[2]), 1);

    // register map table
    wr(GPI_REG_RISE, 32'hFF);
    wr(GPI_REG_FALL, 32'hFF);
    wr(GPI_REG_RISE_EN, 32'h0);
    wr(GPI_REG_FALL_EN, 32'h0);
    for (int i = 0; i < 16; i++) begin
      cs = 1'b1; write = tbl[i].we; reg_addr = tbl[i].a; wr_data = tbl[i].d;
      #1 chk($sformatf("map_%0d", i), rd_data, tbl[i].exp);
      cyc();
    end
    cs = 1'b0; write = 1'b0;
    chk("map_irq", 32'(irq), 0);

    // randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 11) == 0) gpi_in = gpi_in ^ 8'($urandom_range(0, 255));
      reset_n = ($urandom_range(0, 299) != 0);
      cs = 1'($urandom_range(0, 1));
      write = ($urandom_range(0, 3) == 0);
      read = 1'($urandom_range(0, 1));
      reg_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      wr_data = $urandom;
      #1;
      chk("rnd_rd", rd_data, exp_rd(reg_addr));
      chk("rnd_irq", 32'(irq), 32'(m_irq));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
